// File: rtl/register_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: FSM encoding and a
// round-robin pointer helper.
package register_write_arbiter_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  // Index following idx in a ring of r requesters.
  function automatic int rr_next(input int idx, input int r);
    return (idx == r - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/register_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first eligible requester at or after
// rr_ptr (cyclically) wins. Produces both a one-hot grant and its index.
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   eligible,
  input  logic [IDW-1:0] rr_ptr,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  // Scan R positions starting at rr_ptr; the first hit is latched by 'found'.
  always_comb begin
    logic           found;
    int unsigned    c;
    logic [IDW-1:0] c_idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    c_idx   = '0;
    for (int k = 0; k < R; k++) begin
      c     = (int'(rr_ptr) + k) % R;
      c_idx = IDW'(c);
      if (!found && eligible[c_idx]) begin
        found      = 1'b1;
        gnt[c_idx] = 1'b1;
        gnt_idx    = c_idx;
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Shares one N-bit register among R requesters. A grant is taken in IDLE and
// committed one clock later in COMMIT, so at most one write lands every two
// clocks. ack pulses for one cycle per committed write; owner reports the
// requester behind the last commit.
module register_write_arbiter
  import register_write_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] din,
  input  logic           clear,
  output logic [R-1:0]   ack,
  output logic [N-1:0]   qout,
  output logic [IDW-1:0] owner,
  output logic           valid,
  output logic           busy
);

  logic [0:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx_q;
  logic [R-1:0]   gnt_oh_q;
  logic [N-1:0]   data_q;

  logic [R-1:0]   eligible;
  logic [R-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;

  // A requester whose ack is high this cycle may still be holding req a
  // cycle late; masking it prevents a second write of the same data.
  assign eligible = req & ~ack;
  assign busy     = (state == ST_COMMIT);

  rr_arbiter #(.R(R), .IDW(IDW)) u_rr (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  // Two-state grant/commit FSM with the shared register and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      data_q    <= '0;
      qout      <= '0;
      owner     <= '0;
      valid     <= 1'b0;
      ack       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= '0;
          // clear empties the register but does not block arbitration.
          if (clear) begin
            qout  <= '0;
            valid <= 1'b0;
          end
          if (|eligible) begin
            gnt_idx_q <= gnt_idx;
            gnt_oh_q  <= gnt;
            data_q    <= din[int'(gnt_idx)*N +: N];
            state     <= ST_COMMIT;
          end
        end
        default: begin
          // A concurrent clear supersedes the write; the requester is still
          // acked and the pointer still advances, so nothing is retried.
          qout   <= clear ? '0 : data_q;
          valid  <= ~clear;
          owner  <= gnt_idx_q;
          ack    <= gnt_oh_q;
          rr_ptr <= IDW'(rr_next(int'(gnt_idx_q), R));
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
